jx2_reg_gpr_multi: RTL and testbench

- Parametrised successor to the JX2 core GPR file: NREAD combinational read ports and an NFWD-deep forwarding network. Writeback comes from the oldest forwarding stage.
- Adds a per-register pending scoreboard for issue-stall detection.
- Adds a post-reset clear sequencer that zeroes the array one entry per cycle.
- Sits between decode (register IDs and immediates) and the EX stages.

---
 rtl/jx2_regid_pkg.sv | 22 ++
 rtl/jx2_reg_fwd_mux.sv | 36 +++
 rtl/jx2_reg_gpr_multi.sv | 137 +++++++++++++
 tb/tb_jx2_reg_gpr_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/jx2_regid_pkg.sv
// Register-ID encodings, sequencer states and zero constants shared by the JX2 GPR file.
// Special IDs all have the MSB set; ZZR and IMM sit at the top of the ID space.
package jx2_regid_pkg;

  localparam logic [5:0] JX2_GR_PC  = 6'h20;
  localparam logic [5:0] JX2_GR_LR  = 6'h21;
  localparam logic [5:0] JX2_GR_SR  = 6'h22;
  localparam logic [5:0] JX2_GR_DLR = 6'h30;
  localparam logic [5:0] JX2_GR_DHR = 6'h31;
  localparam logic [5:0] JX2_GR_IMM = 6'h3E;
  localparam logic [5:0] JX2_GR_ZZR = 6'h3F;

  localparam logic [31:0] UV32_00 = 32'h0000_0000;
  localparam logic [32:0] UV33_00 = 33'h0_0000_0000;
  localparam logic [63:0] UV64_00 = 64'h0000_0000_0000_0000;

  typedef enum logic [0:0] {
    GPR_CLEAR = 1'b0,
    GPR_RUN   = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/jx2_reg_fwd_mux.sv
// Per-read-port forwarding mux: overrides a base value with the youngest matching
// in-flight stage result and flags that a match occurred.
module jx2_reg_fwd_mux
  import jx2_regid_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IDW   = 6,
  parameter int NFWD  = 3
) (
  input  logic                  fwd_en,
  input  logic [IDW-1:0]        id,
  input  logic [WIDTH-1:0]      base_val,
  input  logic [NFWD*IDW-1:0]   fwd_ids,
  input  logic [NFWD*WIDTH-1:0] fwd_vals,
  output logic [WIDTH-1:0]      val_out,
  output logic                  match
);

  localparam logic [IDW-1:0] ID_ZZR = {IDW{1'b1}};
  localparam logic [IDW-1:0] ID_IMM = {{(IDW-1){1'b1}}, 1'b0};

  // Oldest stage scanned first so a younger match overwrites it.
  always_comb begin
    val_out = base_val;
    match   = 1'b0;
    if (fwd_en && (id != ID_ZZR) && (id != ID_IMM)) begin
      for (int s = NFWD - 1; s >= 0; s--) begin
        if ((fwd_ids[s*IDW +: IDW] == id) && (fwd_ids[s*IDW +: IDW] != ID_ZZR)) begin
          match   = 1'b1;
          val_out = fwd_vals[s*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/jx2_reg_gpr_multi.sv
// Multi-port JX2 GPR file: combinational reads with forwarding, writeback from the
// oldest stage, a pending-write scoreboard and a post-reset array clear sequencer.
module jx2_reg_gpr_multi
  import jx2_regid_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IDW   = 6,
  parameter int NREAD = 3,
  parameter int NFWD  = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [NREAD*IDW-1:0]   regIdRd,
  output logic [NREAD*WIDTH-1:0] regValRd,
  output logic [NREAD-1:0]       regRdPend,
  input  logic [32:0]            regValImm,
  input  logic [NFWD*IDW-1:0]    regIdFwd,
  input  logic [NFWD*WIDTH-1:0]  regValFwd,
  input  logic                   regIssueValid,
  input  logic [IDW-1:0]         regIdIssue,
  output logic                   regBusy
);

  localparam int NGPR = 2 ** (IDW - 1);
  localparam logic [IDW-1:0] ID_IMM = {{(IDW-1){1'b1}}, 1'b0};
  localparam logic [IDW-2:0] PTR_LAST = {(IDW-1){1'b1}};

  gpr_state_e       state_q, state_d;
  logic [IDW-2:0]   ptr_q, ptr_d;
  logic [NGPR-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] arr_q [NGPR];

  logic             wr_en;
  logic [IDW-2:0]   wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [IDW-1:0]   wb_id;
  logic [WIDTH-1:0] wb_val;
  logic [WIDTH-1:0] imm_ext;
  logic             run;

  assign wb_id   = regIdFwd[(NFWD-1)*IDW +: IDW];
  assign wb_val  = regValFwd[(NFWD-1)*WIDTH +: WIDTH];
  assign imm_ext = {{(WIDTH-32){regValImm[32]}}, regValImm[31:0]};
  assign run     = (state_q == GPR_RUN);
  assign regBusy = (state_q == GPR_CLEAR);

  // Pending clear precedes issue set so a same-cycle issue of the written register stays pending.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = '0;
    case (state_q)
      GPR_CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = GPR_RUN;
        end
      end
      default: begin
        if (!hold) begin
          if (!wb_id[IDW-1]) begin
            wr_en          = 1'b1;
            wr_idx         = wb_id[IDW-2:0];
            wr_data        = wb_val;
            pend_d[wr_idx] = 1'b0;
          end
          if (regIssueValid && !regIdIssue[IDW-1]) begin
            pend_d[regIdIssue[IDW-2:0]] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= GPR_CLEAR;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      arr_q[wr_idx] <= wr_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [IDW-1:0]   id_k;
    logic [WIDTH-1:0] base_k;
    logic [WIDTH-1:0] val_k;
    logic             match_k;

    assign id_k = regIdRd[k*IDW +: IDW];

    // Array contents are not trusted until the clear sequencer has finished.
    always_comb begin
      base_k = '0;
      if (!id_k[IDW-1]) begin
        if (run) begin
          base_k = arr_q[id_k[IDW-2:0]];
        end
      end else if (id_k == ID_IMM) begin
        base_k = imm_ext;
      end
    end

    jx2_reg_fwd_mux #(
      .WIDTH (WIDTH),
      .IDW   (IDW),
      .NFWD  (NFWD)
    ) u_fwd (
      .fwd_en   (run),
      .id       (id_k),
      .base_val (base_k),
      .fwd_ids  (regIdFwd),
      .fwd_vals (regValFwd),
      .val_out  (val_k),
      .match    (match_k)
    );

    assign regValRd[k*WIDTH +: WIDTH] = val_k;
    assign regRdPend[k] = run & ~id_k[IDW-1] & pend_q[id_k[IDW-2:0]] & ~match_k;
  end

endmodule

// File: tb/tb_jx2_reg_gpr_multi.sv
// Directed bench for jx2_reg_gpr_multi: clear sequencing, forwarding priority,
// immediate/ZZR reads, scoreboard set/clear and hold behaviour.
module tb_jx2_reg_gpr_multi;

  localparam int WIDTH = 64;
  localparam int IDW   = 6;
  localparam int NREAD = 3;
  localparam int NFWD  = 3;
  localparam logic [IDW-1:0] ZZR = 6'h3F;
  localparam logic [IDW-1:0] IMM = 6'h3E;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   hold;
  logic [NREAD*IDW-1:0]   regIdRd;
  logic [NREAD*WIDTH-1:0] regValRd;
  logic [NREAD-1:0]       regRdPend;
  logic [32:0]            regValImm;
  logic [NFWD*IDW-1:0]    regIdFwd;
  logic [NFWD*WIDTH-1:0]  regValFwd;
  logic                   regIssueValid;
  logic [IDW-1:0]         regIdIssue;
  logic                   regBusy;

  int testsRun    = 0;
  int testsFailed = 0;
  int busyCycles;

  jx2_reg_gpr_multi #(
    .WIDTH (WIDTH),
    .IDW   (IDW),
    .NREAD (NREAD),
    .NFWD  (NFWD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hold          (hold),
    .regIdRd       (regIdRd),
    .regValRd      (regValRd),
    .regRdPend     (regRdPend),
    .regValImm     (regValImm),
    .regIdFwd      (regIdFwd),
    .regValFwd     (regValFwd),
    .regIssueValid (regIssueValid),
    .regIdIssue    (regIdIssue),
    .regBusy       (regBusy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setRead(input logic [IDW-1:0] id0, input logic [IDW-1:0] id1, input logic [IDW-1:0] id2);
    regIdRd = {id2, id1, id0};
  endtask

  task automatic setFwd(input logic [IDW-1:0] id2, input logic [63:0] v2,
                        input logic [IDW-1:0] id1, input logic [63:0] v1,
                        input logic [IDW-1:0] id0, input logic [63:0] v0);
    regIdFwd  = {id2, id1, id0};
    regValFwd = {v2, v1, v0};
  endtask

  function automatic logic [63:0] rd(input int k);
    return regValRd[k*WIDTH +: WIDTH];
  endfunction

  task automatic countBusy(output int cycles);
    cycles = 0;
    while (regBusy && cycles < 100) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; regValImm = '0;
    regIssueValid = 1'b0; regIdIssue = ZZR;
    setRead(ZZR, ZZR, ZZR);
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Clear phase: array reads are zero and a writeback of R5 must not stick.
    setRead(6'd5, IMM, ZZR);
    setFwd(6'd5, 64'hDEAD, ZZR, 0, ZZR, 0);
    #1;
    checkOutput("busy_after_reset", 64'(regBusy), 64'd1);
    checkOutput("clear_read_r5", rd(0), 64'd0);
    checkOutput("clear_pend_r5", 64'(regRdPend[0]), 64'd0);
    countBusy(busyCycles);
    checkOutput("clear_length", 64'(busyCycles), 64'd32);
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    #1;
    checkOutput("busy_low_in_run", 64'(regBusy), 64'd0);
    checkOutput("wb_in_clear_ignored", rd(0), 64'd0);

    // Reset again, then once more ten cycles into the clear.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("busy_mid_clear", 64'(regBusy), 64'd1);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    countBusy(busyCycles);
    checkOutput("clear_restart_length", 64'(busyCycles), 64'd32);

    // Forwarding priority, then the oldest stage lands in the array.
    setRead(6'd7, IMM, ZZR);
    setFwd(6'd7, 64'h11, 6'd7, 64'h22, 6'd7, 64'h33);
    #1;
    checkOutput("fwd_youngest", rd(0), 64'h33);
    setFwd(6'd7, 64'h11, 6'd7, 64'h22, ZZR, 64'h33);
    #1;
    checkOutput("fwd_stage1", rd(0), 64'h22);
    @(negedge clock);
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    #1;
    checkOutput("array_r7", rd(0), 64'h11);

    // Immediate sign extension and ZZR.
    regValImm = 33'h1_8000_0000;
    #1;
    checkOutput("imm_neg", rd(1), 64'hFFFF_FFFF_8000_0000);
    regValImm = 33'h0_7FFF_FFFF;
    #1;
    checkOutput("imm_pos", rd(1), 64'h0000_0000_7FFF_FFFF);
    setFwd(ZZR, 0, ZZR, 0, ZZR, 64'h55);
    #1;
    checkOutput("zzr_read", rd(2), 64'd0);
    checkOutput("imm_pend", 64'(regRdPend[1]), 64'd0);

    // Scoreboard set by issue, masked by forwarding, cleared by writeback.
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    regIssueValid = 1'b1; regIdIssue = 6'd3;
    @(negedge clock);
    regIssueValid = 1'b0;
    setRead(6'd3, IMM, ZZR);
    #1;
    checkOutput("pend_r3_set", 64'(regRdPend[0]), 64'd1);
    setFwd(ZZR, 0, ZZR, 0, 6'd3, 64'h99);
    #1;
    checkOutput("pend_r3_fwd_mask", 64'(regRdPend[0]), 64'd0);
    checkOutput("fwd_r3_val", rd(0), 64'h99);
    setFwd(6'd3, 64'h77, ZZR, 0, ZZR, 0);
    #1;
    checkOutput("pend_r3_wb_mask", 64'(regRdPend[0]), 64'd0);
    @(negedge clock);
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    #1;
    checkOutput("pend_r3_cleared", 64'(regRdPend[0]), 64'd0);
    checkOutput("array_r3", rd(0), 64'h77);

    // Same-cycle issue and writeback of R4: the pending bit survives.
    setFwd(6'd4, 64'h44, ZZR, 0, ZZR, 0);
    regIssueValid = 1'b1; regIdIssue = 6'd4;
    @(negedge clock);
    regIssueValid = 1'b0;
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    setRead(6'd4, IMM, ZZR);
    #1;
    checkOutput("pend_r4_set_wins", 64'(regRdPend[0]), 64'd1);
    checkOutput("array_r4", rd(0), 64'h44);

    // Hold freezes writeback and issue.
    hold = 1'b1;
    setFwd(6'd9, 64'hAB, ZZR, 0, ZZR, 0);
    regIssueValid = 1'b1; regIdIssue = 6'd10;
    @(negedge clock);
    hold = 1'b0;
    regIssueValid = 1'b0;
    setFwd(ZZR, 0, ZZR, 0, ZZR, 0);
    setRead(6'd9, 6'd10, 6'd4);
    #1;
    checkOutput("hold_no_wb_r9", rd(0), 64'd0);
    checkOutput("hold_no_issue_r10", 64'(regRdPend[1]), 64'd0);
    checkOutput("hold_keeps_r4_pend", 64'(regRdPend[2]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
